// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// uart_pkg : shared frame encodings, FSM state types and frame-size helpers
// Revision : 1.0
// ============================================================================
package uart_pkg;

   localparam logic [1:0] TLEN_5 = 2'b00;
   localparam logic [1:0] TLEN_6 = 2'b01;
   localparam logic [1:0] TLEN_7 = 2'b10;
   localparam logic [1:0] TLEN_8 = 2'b11;

   // Last tick index of a bit period and of the half-bit start-bit check.
   localparam logic [3:0] N16_LAST = 4'd15;
   localparam logic [3:0] N13_LAST = 4'd12;
   localparam logic [3:0] H16_LAST = 4'd7;
   localparam logic [3:0] H13_LAST = 4'd5;

   typedef enum logic [2:0] {
      TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
   } tx_state_e;

   typedef enum logic [2:0] {
      RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP
   } rx_state_e;

   function automatic logic [3:0] data_bits(input logic [1:0] tl);
      return 4'd5 + {2'b00, tl};
   endfunction

   function automatic logic [7:0] data_mask(input logic [1:0] tl);
      return 8'hFF >> (2'd3 - tl);
   endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_gen.sv
`default_nettype none
// ============================================================================
// uart_baud_gen : divides clk down to the oversampling tick (x16 or x13)
// Revision      : 1.0
// ============================================================================
module uart_baud_gen #(
   parameter int DIV_X16 = 15,
   parameter int DIV_X13 = 18
) (
   input  logic clk,
   input  logic rst_n,
   input  logic bclk_mode,
   output logic tick
);

   localparam int DMAX = (DIV_X16 > DIV_X13) ? DIV_X16 : DIV_X13;
   localparam int CW   = (DMAX > 2) ? $clog2(DMAX) : 1;

   logic [CW-1:0] cnt;
   logic [CW-1:0] div_last;

   assign div_last = bclk_mode ? CW'(DIV_X13 - 1) : CW'(DIV_X16 - 1);

   // >= so a mode switch to the shorter divisor never overshoots the wrap.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt  <= '0;
         tick <= 1'b0;
      end else if (cnt >= div_last) begin
         cnt  <= '0;
         tick <= 1'b1;
      end else begin
         cnt  <= cnt + CW'(1);
         tick <= 1'b0;
      end
   end

endmodule
`default_nettype wire

// File: rtl/uart_top.sv
`default_nettype none
// ============================================================================
// uart_top : full-duplex UART, 5-8 data bits, optional parity, 1 stop bit
// Revision : 1.0
// ============================================================================
module uart_top
   import uart_pkg::*;
#(
   parameter int DIV_X16 = 15,
   parameter int DIV_X13 = 18
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       wr_en,
   input  logic [1:0] tlen,
   input  logic       parity_en,
   input  logic       parity_type,
   input  logic       bclk_mode,
   input  logic [7:0] wdata,
   input  logic       RXD,
   output logic [7:0] rdata,
   output logic       TXD,
   output logic       parity_err,
   output logic       frame_err
);

   logic       tick;
   logic [3:0] n_last;
   logic [3:0] half_last;

   uart_baud_gen #(.DIV_X16(DIV_X16), .DIV_X13(DIV_X13)) u_baud (
      .clk       (clk),
      .rst_n     (rst_n),
      .bclk_mode (bclk_mode),
      .tick      (tick)
   );

   assign n_last    = bclk_mode ? N13_LAST : N16_LAST;
   assign half_last = bclk_mode ? H13_LAST : H16_LAST;

   // ---------------------------------------------------------------- TX
   tx_state_e  tx_state;
   logic [3:0] tx_tick;
   logic [2:0] tx_bit;
   logic [7:0] tx_shift;
   logic [1:0] tx_len;
   logic       tx_pen;
   logic       tx_par;
   logic       tx_end;
   logic       tx_load;

   assign tx_end  = tick && (tx_tick == n_last);
   assign tx_load = wr_en && ((tx_state == TX_IDLE) || ((tx_state == TX_STOP) && tx_end));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_state <= TX_IDLE;
         tx_tick  <= '0;
         tx_bit   <= '0;
         tx_shift <= '0;
         tx_len   <= TLEN_8;
         tx_pen   <= 1'b0;
         tx_par   <= 1'b0;
         TXD      <= 1'b1;
      end else if (tx_load) begin
         tx_state <= TX_START;
         tx_tick  <= '0;
         tx_shift <= wdata & data_mask(tlen);
         tx_len   <= tlen;
         tx_pen   <= parity_en;
         tx_par   <= (^(wdata & data_mask(tlen))) ^ parity_type;
         TXD      <= 1'b0;
      end else if ((tx_state != TX_IDLE) && tick) begin
         if (!tx_end) begin
            tx_tick <= tx_tick + 4'd1;
         end else begin
            tx_tick <= '0;
            case (tx_state)
               TX_START: begin
                  tx_state <= TX_DATA;
                  tx_bit   <= '0;
                  TXD      <= tx_shift[0];
                  tx_shift <= tx_shift >> 1;
               end
               TX_DATA: begin
                  if ({1'b0, tx_bit} == data_bits(tx_len) - 4'd1) begin
                     tx_state <= tx_pen ? TX_PARITY : TX_STOP;
                     TXD      <= tx_pen ? tx_par : 1'b1;
                  end else begin
                     tx_bit   <= tx_bit + 3'd1;
                     TXD      <= tx_shift[0];
                     tx_shift <= tx_shift >> 1;
                  end
               end
               TX_PARITY: begin
                  tx_state <= TX_STOP;
                  TXD      <= 1'b1;
               end
               default: tx_state <= TX_IDLE;
            endcase
         end
      end
   end

   // ---------------------------------------------------------------- RX
   rx_state_e  rx_state;
   logic       rx_m, rx_s, rx_prev;
   logic [3:0] rx_tick;
   logic [2:0] rx_bit;
   logic [7:0] rx_shift;
   logic [1:0] rx_len;
   logic       rx_pen, rx_ptype, rx_par, rx_pbit;
   logic       rx_end;

   assign rx_end = tick && (rx_tick == ((rx_state == RX_START) ? half_last : n_last));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_m       <= 1'b1;
         rx_s       <= 1'b1;
         rx_prev    <= 1'b1;
         rx_state   <= RX_IDLE;
         rx_tick    <= '0;
         rx_bit     <= '0;
         rx_shift   <= '0;
         rx_len     <= TLEN_8;
         rx_pen     <= 1'b0;
         rx_ptype   <= 1'b0;
         rx_par     <= 1'b0;
         rx_pbit    <= 1'b0;
         rdata      <= '0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         rx_m    <= RXD;
         rx_s    <= rx_m;
         rx_prev <= rx_s;
         if (rx_state == RX_IDLE) begin
            if (rx_prev && !rx_s) begin
               rx_state <= RX_START;
               rx_tick  <= '0;
               rx_bit   <= '0;
               rx_shift <= '0;
               rx_par   <= 1'b0;
               rx_len   <= tlen;
               rx_pen   <= parity_en;
               rx_ptype <= parity_type;
            end
         end else if (tick) begin
            if (!rx_end) begin
               rx_tick <= rx_tick + 4'd1;
            end else begin
               rx_tick <= '0;
               case (rx_state)
                  RX_START: rx_state <= rx_s ? RX_IDLE : RX_DATA;
                  RX_DATA: begin
                     rx_shift[rx_bit] <= rx_s;
                     rx_par           <= rx_par ^ rx_s;
                     if ({1'b0, rx_bit} == data_bits(rx_len) - 4'd1)
                        rx_state <= rx_pen ? RX_PARITY : RX_STOP;
                     else
                        rx_bit <= rx_bit + 3'd1;
                  end
                  RX_PARITY: begin
                     rx_pbit  <= rx_s;
                     rx_state <= RX_STOP;
                  end
                  default: begin
                     rdata      <= rx_shift;
                     parity_err <= rx_pen && (rx_par ^ rx_ptype ^ rx_pbit);
                     frame_err  <= !rx_s;
                     rx_state   <= RX_IDLE;
                  end
               endcase
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_uart_top.sv
`default_nettype none
// ============================================================================
// tb_uart_top : loopback and directed-frame bench for uart_top
// Revision    : 1.0
// ============================================================================
module tb_uart_top;

   localparam int DIV_X16 = 15;
   localparam int DIV_X13 = 18;
   localparam int BIT16   = 16 * DIV_X16;
   localparam int BIT13   = 13 * DIV_X13;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       wr_en;
   logic [1:0] tlen;
   logic       parity_en, parity_type, bclk_mode;
   logic [7:0] wdata;
   logic       rxd, txd;
   logic [7:0] rdata;
   logic       parity_err, frame_err;
   logic       inject, bench_rxd;

   int checks   = 0;
   int failures = 0;

   assign rxd = inject ? bench_rxd : txd;

   always #5 clk = ~clk;

   uart_top #(.DIV_X16(DIV_X16), .DIV_X13(DIV_X13)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .wr_en       (wr_en),
      .tlen        (tlen),
      .parity_en   (parity_en),
      .parity_type (parity_type),
      .bclk_mode   (bclk_mode),
      .wdata       (wdata),
      .RXD         (rxd),
      .rdata       (rdata),
      .TXD         (txd),
      .parity_err  (parity_err),
      .frame_err   (frame_err)
   );

   typedef struct {
      logic [1:0] tlen;
      logic       pen;
      logic       ptype;
      logic [7:0] wdata;
      logic [7:0] exp_rdata;
      logic       exp_perr;
      logic       exp_ferr;
   } vec_t;

   vec_t vecs[8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_txd(input logic lvl, input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget && !ok; i++) begin
         @(negedge clk);
         if (txd === lvl) ok = 1'b1;
      end
   endtask

   task automatic wait_rdata_change(input logic [7:0] prev, input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget && !ok; i++) begin
         @(negedge clk);
         if (rdata !== prev) ok = 1'b1;
      end
   endtask

   task automatic drive_frame(input logic [7:0] d, input int nbits, input bit pen,
                              input logic pbit, input logic stopb);
      bench_rxd = 1'b0;
      wait_clk(BIT16);
      for (int i = 0; i < nbits; i++) begin
         bench_rxd = d[i];
         wait_clk(BIT16);
      end
      if (pen) begin
         bench_rxd = pbit;
         wait_clk(BIT16);
      end
      bench_rxd = stopb;
      wait_clk(BIT16);
      bench_rxd = 1'b1;
      wait_clk(BIT16);
   endtask

   initial begin
      #3_000_000;
      $display("FAIL global_timeout: actual=running expected=finished");
      $fatal(1, "simulation time limit");
   end

   initial begin
      bit         ok;
      int         lows;
      int         bit_clks;
      logic [7:0] prev;

      vecs[0] = '{2'b11, 1'b0, 1'b0, 8'hEB, 8'hEB, 1'b0, 1'b0};
      vecs[1] = '{2'b10, 1'b0, 1'b0, 8'hEB, 8'h6B, 1'b0, 1'b0};
      vecs[2] = '{2'b01, 1'b0, 1'b0, 8'hEB, 8'h2B, 1'b0, 1'b0};
      vecs[3] = '{2'b00, 1'b0, 1'b0, 8'hEB, 8'h0B, 1'b0, 1'b0};
      vecs[4] = '{2'b11, 1'b1, 1'b0, 8'h5A, 8'h5A, 1'b0, 1'b0};
      vecs[5] = '{2'b11, 1'b1, 1'b1, 8'h3C, 8'h3C, 1'b0, 1'b0};
      vecs[6] = '{2'b10, 1'b1, 1'b1, 8'h81, 8'h01, 1'b0, 1'b0};
      vecs[7] = '{2'b00, 1'b1, 1'b0, 8'hFF, 8'h1F, 1'b0, 1'b0};

      rst_n = 1'b0; wr_en = 1'b0; tlen = 2'b11; parity_en = 1'b0; parity_type = 1'b0;
      bclk_mode = 1'b0; wdata = 8'h00; inject = 1'b0; bench_rxd = 1'b1;
      wait_clk(4);
      chk("reset_txd", txd, 1);
      chk("reset_rdata", rdata, 8'h00);
      chk("reset_perr", parity_err, 0);
      chk("reset_ferr", frame_err, 0);
      rst_n = 1'b1;
      wait_clk(5);

      // Back-to-back loopback; next config is applied when the previous frame lands.
      prev = rdata;
      for (int i = 0; i < 8; i++) begin
         tlen = vecs[i].tlen; parity_en = vecs[i].pen; parity_type = vecs[i].ptype;
         wdata = vecs[i].wdata; wr_en = 1'b1;
         wait_rdata_change(prev, 4000, ok);
         chk($sformatf("vec%0d_arrived", i), ok, 1);
         chk($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rdata);
         chk($sformatf("vec%0d_perr", i), parity_err, vecs[i].exp_perr);
         chk($sformatf("vec%0d_ferr", i), frame_err, vecs[i].exp_ferr);
         prev = rdata;
      end
      wr_en = 1'b0;
      wait_clk(600);

      // Even parity on 0xEA (five ones) gives a parity bit of 1; wr_en drops mid-frame.
      rst_n = 1'b0;
      tlen = 2'b11; parity_en = 1'b1; parity_type = 1'b0; wdata = 8'hEA; wr_en = 1'b1;
      wait_clk(3);
      rst_n = 1'b1;
      wait_txd(1'b0, 100, ok);
      chk("par_start_seen", ok, 1);
      wait_clk(300);
      wr_en = 1'b0;
      wait_clk(9 * BIT16 + BIT16 / 2 - 300);
      chk("par_tx_bit", txd, 1);
      wait_rdata_change(8'h00, 4000, ok);
      chk("par_arrived", ok, 1);
      chk("par_rdata", rdata, 8'hEA);
      chk("par_perr", parity_err, 0);
      chk("par_ferr", frame_err, 0);
      lows = 0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (txd !== 1'b1) lows++;
      end
      chk("par_txd_idle_lows", lows, 0);

      // x13 oversampling: 0xAA alternates, so bit 1 (high) is exactly one bit time.
      bclk_mode = 1'b1; parity_en = 1'b0; wdata = 8'hAA; wr_en = 1'b1;
      wait_txd(1'b0, 400, ok);
      chk("x13_start_seen", ok, 1);
      wait_txd(1'b1, 1000, ok);
      chk("x13_rise_seen", ok, 1);
      bit_clks = 0;
      ok = 1'b0;
      for (int i = 0; i < 1000 && !ok; i++) begin
         @(negedge clk);
         bit_clks++;
         if (txd === 1'b0) ok = 1'b1;
      end
      chk("x13_bit_clks", bit_clks, BIT13);
      wait_rdata_change(8'hEA, 4000, ok);
      wr_en = 1'b0;
      chk("x13_arrived", ok, 1);
      chk("x13_rdata", rdata, 8'hAA);
      wait_clk(500);

      // Bench-driven frames with a bad parity bit, then a zero stop bit.
      bclk_mode = 1'b0; inject = 1'b1; bench_rxd = 1'b1;
      tlen = 2'b11; parity_en = 1'b1; parity_type = 1'b0;
      wait_clk(300);
      drive_frame(8'h55, 8, 1'b1, 1'b1, 1'b1);
      chk("badpar_rdata", rdata, 8'h55);
      chk("badpar_perr", parity_err, 1);
      chk("badpar_ferr", frame_err, 0);
      wait_clk(500);
      chk("badpar_perr_hold", parity_err, 1);
      drive_frame(8'h33, 8, 1'b1, 1'b0, 1'b0);
      chk("badstop_rdata", rdata, 8'h33);
      chk("badstop_perr", parity_err, 0);
      chk("badstop_ferr", frame_err, 1);

      // Reset during a start bit clears everything without waiting for a clock.
      inject = 1'b0; parity_en = 1'b0; wdata = 8'h96; wr_en = 1'b1;
      wait_txd(1'b0, 400, ok);
      chk("rst_start_seen", ok, 1);
      wait_clk(100);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_txd", txd, 1);
      chk("midrst_rdata", rdata, 8'h00);
      chk("midrst_perr", parity_err, 0);
      chk("midrst_ferr", frame_err, 0);
      wait_clk(3);
      rst_n = 1'b1;
      wait_rdata_change(8'h00, 4000, ok);
      wr_en = 1'b0;
      chk("postrst_arrived", ok, 1);
      chk("postrst_rdata", rdata, 8'h96);
      chk("postrst_ferr", frame_err, 0);
      wait_clk(300);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
